// File: rtl/pio_arb_pkg.sv
// Shared types and constants for the PIO APB arbiter and its round-robin picker.
//   arb_state_e : arbiter FSM state (IDLE, SETUP, ACCESS)
//   MAX_NM      : largest supported number of upstream requesters
//   APB_DW/SW/PW: APB data, strobe and prot widths
package pio_arb_pkg;

  localparam int unsigned MAX_NM = 8;

  localparam int unsigned APB_DW = 32;
  localparam int unsigned APB_SW = 4;
  localparam int unsigned APB_PW = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } arb_state_e;

endpackage

// File: rtl/pio_rr_pick.sv
// Combinational round-robin picker.
// Returns the first candidate (req & ~excl) found at or after ptr, wrapping modulo NM.
//   req   in  NM  request vector
//   ptr   in  IW  starting index for the search
//   excl  in  NM  requesters to ignore this time
//   valid out 1   some candidate exists
//   idx   out IW  index of the chosen candidate (0 when none)
module pio_rr_pick #(
  parameter int unsigned NM = 2,
  localparam int unsigned IW = (NM > 1) ? $clog2(NM) : 1
) (
  input  logic [NM-1:0] req,
  input  logic [IW-1:0] ptr,
  input  logic [NM-1:0] excl,
  output logic          valid,
  output logic [IW-1:0] idx
);

  logic [NM-1:0] cand;
  assign cand = req & ~excl;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    // Scan from the farthest position back to ptr so the nearest candidate is written last.
    for (int k = int'(NM) - 1; k >= 0; k--) begin
      if (cand[(int'(ptr) + k) % int'(NM)]) begin
        valid = 1'b1;
        idx   = IW'((int'(ptr) + k) % int'(NM));
      end
    end
  end

endmodule

// File: rtl/pio_apb_arb.sv
// Round-robin arbiter sharing the PIO APB slave port between NM APB requesters.
// The grant is held for a whole transfer; losing requesters see extended wait states.
// Optional feature macro: PIO_APB_ARB_TIMEOUT_EN (access-phase timeout, adds tmo_flag).
// Ports:
//   pclk, reset                  clock, asynchronous active-high reset
//   m_psel/penable/pwrite        per-requester APB controls (NM bits each)
//   m_paddr/pwdata/pstrb/pprot   packed per-requester address/data/strobe/prot
//   m_prdata/pready/pslverr      per-requester responses
//   psel/penable/pwrite/paddr/pwdata/pstrb/pprot  downstream APB master request
//   prdata/pready/pslverr        downstream APB response
//   apbactive                    clock-gate hint (any request or transfer in flight)
//   grant                        current owner index
//   tmo_flag                     sticky timeout indicator (timeout build only)
module pio_apb_arb
  import pio_arb_pkg::*;
#(
  parameter int unsigned NM         = 2,
  parameter int unsigned AW         = 12,
  parameter int unsigned TMO_CYCLES = 255,
  localparam int unsigned GW        = $clog2(NM)
) (
  input  logic                 pclk,
  input  logic                 reset,
  input  logic [NM-1:0]        m_psel,
  input  logic [NM-1:0]        m_penable,
  input  logic [NM-1:0]        m_pwrite,
  input  logic [NM*AW-1:0]     m_paddr,
  input  logic [NM*APB_DW-1:0] m_pwdata,
  input  logic [NM*APB_SW-1:0] m_pstrb,
  input  logic [NM*APB_PW-1:0] m_pprot,
  output logic [NM*APB_DW-1:0] m_prdata,
  output logic [NM-1:0]        m_pready,
  output logic [NM-1:0]        m_pslverr,
  output logic                 psel,
  output logic                 penable,
  output logic                 pwrite,
  output logic [AW-1:0]        paddr,
  output logic [APB_DW-1:0]    pwdata,
  output logic [APB_SW-1:0]    pstrb,
  output logic [APB_PW-1:0]    pprot,
  input  logic [APB_DW-1:0]    prdata,
  input  logic                 pready,
  input  logic                 pslverr,
  output logic                 apbactive,
  output logic [GW-1:0]        grant
`ifdef PIO_APB_ARB_TIMEOUT_EN
  ,
  output logic                 tmo_flag
`endif
);

  arb_state_e    state_q;
  logic [GW-1:0] grant_q, ptr_q, next_ptr;
  logic [NM-1:0] grant_oh, pick_excl;
  logic [GW-1:0] pick_ptr, pick_idx;
  logic          pick_valid;
  logic          active, done, tmo_hit;
  logic [31:0]   gsel;

  // Requester enable phase is implied by our own SETUP/ACCESS sequencing.
  logic unused_penable;
  assign unused_penable = ^m_penable;
  logic unused_cfg;
  assign unused_cfg = ^{32'(TMO_CYCLES), 32'(MAX_NM)};

  assign active   = (state_q != IDLE);
  assign gsel     = 32'(grant_q);
  assign next_ptr = (grant_q == GW'(NM - 1)) ? '0 : grant_q + GW'(1);

  always_comb begin
    grant_oh          = '0;
    grant_oh[grant_q] = 1'b1;
  end

  // In IDLE search from the stored pointer; on completion search past the finished owner
  // and never hand the bus straight back to it.
  assign pick_ptr  = active ? next_ptr : ptr_q;
  assign pick_excl = active ? grant_oh : '0;

  pio_rr_pick #(
    .NM(NM)
  ) u_pick (
    .req  (m_psel),
    .ptr  (pick_ptr),
    .excl (pick_excl),
    .valid(pick_valid),
    .idx  (pick_idx)
  );

`ifdef PIO_APB_ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt_q;
  logic        tmo_flag_q;

  assign tmo_hit  = (state_q == ACCESS) && !pready && (tmo_cnt_q >= 16'(TMO_CYCLES));
  assign tmo_flag = tmo_flag_q;

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      tmo_cnt_q  <= '0;
      tmo_flag_q <= 1'b0;
    end else begin
      if (state_q == SETUP) begin
        tmo_cnt_q <= '0;
      end else if ((state_q == ACCESS) && !pready && !tmo_hit) begin
        tmo_cnt_q <= tmo_cnt_q + 16'd1;
      end
      if (tmo_hit) begin
        tmo_flag_q <= 1'b1;
      end
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  assign done = (state_q == ACCESS) && (pready || tmo_hit);

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            grant_q <= pick_idx;
            state_q <= SETUP;
          end
        end
        SETUP: state_q <= ACCESS;
        ACCESS: begin
          if (done) begin
            ptr_q <= next_ptr;
            if (pick_valid) begin
              grant_q <= pick_idx;
              state_q <= SETUP;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign psel      = active;
  assign penable   = (state_q == ACCESS);
  assign grant     = grant_q;
  assign apbactive = (|m_psel) || active;
  assign m_prdata  = {NM{prdata}};

  // Downstream request is forced to zero while idle so nothing leaks from requester 0.
  always_comb begin
    pwrite = 1'b0;
    paddr  = '0;
    pwdata = '0;
    pstrb  = '0;
    pprot  = '0;
    if (active) begin
      pwrite = m_pwrite[grant_q];
      paddr  = m_paddr[gsel*AW +: AW];
      pwdata = m_pwdata[gsel*APB_DW +: APB_DW];
      pstrb  = m_pstrb[gsel*APB_SW +: APB_SW];
      pprot  = m_pprot[gsel*APB_PW +: APB_PW];
    end
  end

  always_comb begin
    m_pready  = '0;
    m_pslverr = '0;
    if (done) begin
      m_pready[grant_q]  = 1'b1;
      m_pslverr[grant_q] = pslverr | tmo_hit;
    end
  end

endmodule

// File: tb/tb_pio_apb_arb.sv
// Scoreboard bench for pio_apb_arb: the sequencer queues the expected completions and a
// monitor checks each completion the arbiter presents against the head of the queue.
module tb_pio_apb_arb;

  localparam int unsigned NM = 2;
  localparam int unsigned AW = 12;

  logic              pclk = 1'b0;
  logic              reset;
  logic [NM-1:0]     m_psel, m_penable, m_pwrite;
  logic [NM*AW-1:0]  m_paddr;
  logic [NM*32-1:0]  m_pwdata;
  logic [NM*4-1:0]   m_pstrb;
  logic [NM*3-1:0]   m_pprot;
  logic [NM*32-1:0]  m_prdata;
  logic [NM-1:0]     m_pready, m_pslverr;
  logic              psel, penable, pwrite;
  logic [AW-1:0]     paddr;
  logic [31:0]       pwdata;
  logic [3:0]        pstrb;
  logic [2:0]        pprot;
  logic [31:0]       prdata;
  logic              pready, pslverr;
  logic              apbactive;
  logic [0:0]        grant;
`ifdef PIO_APB_ARB_TIMEOUT_EN
  logic              tmo_flag;
`endif

  pio_apb_arb #(
    .NM(NM), .AW(AW), .TMO_CYCLES(8)
  ) dut (
    .pclk(pclk), .reset(reset),
    .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite), .m_paddr(m_paddr),
    .m_pwdata(m_pwdata), .m_pstrb(m_pstrb), .m_pprot(m_pprot), .m_prdata(m_prdata),
    .m_pready(m_pready), .m_pslverr(m_pslverr),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pstrb(pstrb), .pprot(pprot), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .apbactive(apbactive), .grant(grant)
`ifdef PIO_APB_ARB_TIMEOUT_EN
    , .tmo_flag(tmo_flag)
`endif
  );

  always #5 pclk = ~pclk;

  // Downstream slave: inserts slv_wait wait states per ACCESS phase.
  int          slv_wait;
  int          acc_cnt;
  logic [31:0] slv_rdata;
  logic        slv_err;

  always @(posedge pclk or posedge reset) begin
    if (reset) acc_cnt <= 0;
    else if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end
  assign pready  = psel && penable && (acc_cnt >= slv_wait);
  assign prdata  = slv_rdata;
  assign pslverr = slv_err;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          idx;
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb_q[$];

  task automatic expect_xfer(input int idx, input logic wr, input logic [11:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rdata,
                             input logic err);
    exp_t e;
    e.idx = idx; e.wr = wr; e.addr = addr; e.wdata = wdata; e.rdata = rdata; e.err = err;
    sb_q.push_back(e);
  endtask

  always @(negedge pclk) begin : monitor
    exp_t          e;
    logic [NM-1:0] oh;
    if (!reset && (m_pready != '0)) begin
      if (sb_q.size() == 0) begin
        chk("sb unexpected completion", 64'(m_pready), 64'd0);
      end else begin
        e = sb_q.pop_front();
        oh = '0;
        oh[e.idx] = 1'b1;
        chk("done owner", 64'(m_pready), 64'(oh));
        chk("done grant", 64'(grant), 64'(e.idx));
        chk("done pslverr", 64'(m_pslverr), e.err ? 64'(oh) : 64'd0);
        chk("done paddr", 64'(paddr), 64'(e.addr));
        chk("done pwrite", 64'(pwrite), 64'(e.wr));
        chk("done pwdata", 64'(pwdata), 64'(e.wdata));
        chk("done prdata", 64'(m_prdata[e.idx*32 +: 32]), 64'(e.rdata));
      end
    end
  end

  task automatic drive_req(input int i, input logic wr, input logic [11:0] a,
                           input logic [31:0] d);
    m_psel[i]            = 1'b1;
    m_penable[i]         = 1'b0;
    m_pwrite[i]          = wr;
    m_paddr[i*AW +: AW]  = a;
    m_pwdata[i*32 +: 32] = d;
    m_pstrb[i*4 +: 4]    = wr ? 4'hF : 4'h0;
    m_pprot[i*3 +: 3]    = 3'(i);
  endtask

  task automatic drop_req(input int i);
    m_psel[i]    = 1'b0;
    m_penable[i] = 1'b0;
  endtask

  // Full requester transfer, entered on a falling edge; returns one cycle after completion.
  task automatic xfer(input int i, input logic wr, input logic [11:0] a, input logic [31:0] d);
    bit seen = 1'b0;
    drive_req(i, wr, a, d);
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge pclk);
      m_penable[i] = 1'b1;
      if (m_pready[i]) seen = 1'b1;
    end
    chk("xfer completed within bound", 64'(seen), 64'd1);
    @(negedge pclk);
    drop_req(i);
  endtask

  task automatic do_reset();
    @(negedge pclk);
    reset = 1'b1;
    @(negedge pclk);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100000");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    m_psel = '0; m_penable = '0; m_pwrite = '0; m_paddr = '0;
    m_pwdata = '0; m_pstrb = '0; m_pprot = '0;
    slv_wait = 0; slv_rdata = '0; slv_err = 1'b0;
    @(negedge pclk);
    @(negedge pclk);

    chk("rst psel/penable", 64'({psel, penable}), 64'd0);
    chk("rst paddr", 64'(paddr), 64'd0);
    chk("rst pwdata", 64'(pwdata), 64'd0);
    chk("rst pwrite/pstrb/pprot", 64'({pwrite, pstrb, pprot}), 64'd0);
    chk("rst m_pready/m_pslverr", 64'({m_pready, m_pslverr}), 64'd0);
    chk("rst apbactive", 64'(apbactive), 64'd0);
    chk("rst grant", 64'(grant), 64'd0);
`ifdef PIO_APB_ARB_TIMEOUT_EN
    chk("rst tmo_flag", 64'(tmo_flag), 64'd0);
`endif
    reset = 1'b0;

    // Single write from requester 0, zero wait states.
    expect_xfer(0, 1'b1, 12'h0C8, 32'hDEADBEEF, 32'h0, 1'b0);
    @(negedge pclk);
    drive_req(0, 1'b1, 12'h0C8, 32'hDEADBEEF);
    #1;
    chk("t1 c0 psel idle", 64'(psel), 64'd0);
    chk("t1 c0 apbactive", 64'(apbactive), 64'd1);
    @(negedge pclk);
    m_penable[0] = 1'b1;
    chk("t1 c1 setup", 64'({psel, penable}), 64'b10);
    chk("t1 c1 paddr", 64'(paddr), 64'h0C8);
    @(negedge pclk);
    chk("t1 c2 access+ready", 64'({psel, penable, m_pready}), 64'b1101);
    @(negedge pclk);
    drop_req(0);
    #1;
    chk("t1 c3 back to idle", 64'({psel, penable, apbactive}), 64'd0);

    // Both requesters every transfer: strict alternation, no idle gap between owners.
    do_reset();
    slv_rdata = 32'h0;
    expect_xfer(0, 1'b1, 12'h100, 32'h11111111, 32'h0, 1'b0);
    expect_xfer(1, 1'b1, 12'h200, 32'h22222222, 32'h0, 1'b0);
    expect_xfer(0, 1'b1, 12'h104, 32'h33333333, 32'h0, 1'b0);
    expect_xfer(1, 1'b1, 12'h204, 32'h44444444, 32'h0, 1'b0);
    @(negedge pclk);
    fork
      begin
        xfer(0, 1'b1, 12'h100, 32'h11111111);
        xfer(0, 1'b1, 12'h104, 32'h33333333);
      end
      begin
        xfer(1, 1'b1, 12'h200, 32'h22222222);
        xfer(1, 1'b1, 12'h204, 32'h44444444);
      end
      begin
        repeat (3) @(negedge pclk);
        chk("t2 c3 direct setup to r1", 64'({psel, penable, grant}), 64'b101);
        repeat (2) @(negedge pclk);
        chk("t2 c5 direct setup to r0", 64'({psel, penable, grant}), 64'b100);
      end
    join

    // Read with five downstream wait states.
    slv_wait = 5;
    slv_rdata = 32'h12345678;
    expect_xfer(1, 1'b0, 12'h3FC, 32'h0, 32'h12345678, 1'b0);
    @(negedge pclk);
    drive_req(1, 1'b0, 12'h3FC, 32'h0);
    @(negedge pclk);
    m_penable[1] = 1'b1;
    chk("t3 setup paddr", 64'(paddr), 64'h3FC);
    for (int k = 1; k <= 6; k++) begin
      @(negedge pclk);
      chk("t3 access paddr stable", 64'(paddr), 64'h3FC);
      chk("t3 m_pready only on 6th", 64'(m_pready[1]), 64'(k == 6));
    end
    @(negedge pclk);
    drop_req(1);
    slv_wait = 0;

    // Slave error goes only to the owner of each transfer.
    slv_err = 1'b1;
    slv_rdata = 32'hCAFE0000;
    expect_xfer(0, 1'b1, 12'h020, 32'hA0A0A0A0, 32'hCAFE0000, 1'b1);
    expect_xfer(1, 1'b0, 12'h024, 32'h0, 32'hCAFE0000, 1'b1);
    @(negedge pclk);
    fork
      xfer(0, 1'b1, 12'h020, 32'hA0A0A0A0);
      xfer(1, 1'b0, 12'h024, 32'h0);
    join
    slv_err = 1'b0;

    // Reset in the middle of requester 1's access phase, with the pointer at 1.
    slv_wait = 3;
    expect_xfer(0, 1'b1, 12'h030, 32'h55, 32'hCAFE0000, 1'b0);
    @(negedge pclk);
    xfer(0, 1'b1, 12'h030, 32'h55);
    drive_req(1, 1'b1, 12'h034, 32'h66);
    @(negedge pclk);
    m_penable[1] = 1'b1;
    @(negedge pclk);
    chk("t5 in access for r1", 64'({psel, penable, grant}), 64'b111);
    reset = 1'b1;
    #1;
    chk("t5 abort drops psel/penable", 64'({psel, penable}), 64'd0);
    chk("t5 abort no m_pready", 64'(m_pready), 64'd0);
    @(negedge pclk);
    drop_req(1);
    reset = 1'b0;
    #1;
    chk("t5 idle after release", 64'({psel, penable, apbactive}), 64'd0);
    slv_wait = 0;
    // Pointer back at 0: requester 0 must win the tie.
    expect_xfer(0, 1'b1, 12'h040, 32'h77, 32'hCAFE0000, 1'b0);
    expect_xfer(1, 1'b1, 12'h044, 32'h88, 32'hCAFE0000, 1'b0);
    @(negedge pclk);
    fork
      xfer(0, 1'b1, 12'h040, 32'h77);
      xfer(1, 1'b1, 12'h044, 32'h88);
    join

`ifdef PIO_APB_ARB_TIMEOUT_EN
    begin
      int acc;
      bit seen;
      acc = 0;
      seen = 1'b0;
      slv_wait = 1000;
      slv_rdata = 32'h0BADF00D;
      expect_xfer(0, 1'b0, 12'h050, 32'h0, 32'h0BADF00D, 1'b1);
      @(negedge pclk);
      drive_req(0, 1'b0, 12'h050, 32'h0);
      for (int n = 0; n < 50 && !seen; n++) begin
        @(negedge pclk);
        m_penable[0] = 1'b1;
        if (psel && penable) acc++;
        if (m_pready[0]) seen = 1'b1;
      end
      chk("t6 timeout completion", 64'(seen), 64'd1);
      chk("t6 access cycles incl. completion", 64'(acc), 64'd9);
      chk("t6 flag clear before completion edge", 64'(tmo_flag), 64'd0);
      @(negedge pclk);
      drop_req(0);
      chk("t6 tmo_flag set", 64'(tmo_flag), 64'd1);
      chk("t6 downstream released", 64'({psel, penable}), 64'd0);
      repeat (3) @(negedge pclk);
      chk("t6 tmo_flag sticky", 64'(tmo_flag), 64'd1);
      slv_wait = 0;
    end
`endif

    repeat (2) @(negedge pclk);
    chk("sb drained", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
